sram_init_ctrl: RTL and testbench
=================================

SRAM_INIT_CTRL -- requirements
Module: sram_init_ctrl

Interface
REQ-001 SHALL have parameter AW, default 12: byte-address width; SRAM holds 2^(AW-2) words.
REQ-002 SHALL have parameter INIT_VALUE, default 32'h0000_0000: word written to every location on clear.
REQ-003 SHALL have parameter AUTO_INIT, default 1: 1 = clear starts automatically after reset.
REQ-004 SHALL have port HCLK  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port HRESET  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports HSEL, HTRANS[1:0], HADDR[31:0], HWRITE, HSIZE[2:0], HREADY  in  AHB address-phase signals from the bus.
REQ-007 SHALL have port HREADYOUT  out  1  bus ready.
REQ-008 SHALL have ports s_HSEL, s_HTRANS[1:0], s_HADDR[31:0], s_HWRITE, s_HSIZE[2:0], s_HREADY  out  address phase driven to the SRAM bridge.
REQ-009 SHALL have port s_HREADYOUT  in  1  bridge ready (always 1 from the bridge).
REQ-010 SHALL have ports b_SRAMCS 1, b_SRAMWEN 4, b_SRAMADDR AW-2, b_SRAMWDATA 32  in  bridge SRAM request.
REQ-011 SHALL have ports SRAMCS 1, SRAMWEN 4, SRAMADDR AW-2, SRAMWDATA 32  out  to SRAM macro.
REQ-012 SHALL have port init_start  in  1  request a full clear; init_busy  out  1  clear in progress; init_done  out  1  sticky, last clear complete.
REQ-013 HWDATA, HRDATA and SRAMRDATA SHALL bypass this block.

Function
REQ-014 FSM states SHALL be IDLE, CLEAR and REPLAY; init_busy = (state != IDLE).
REQ-015 IDLE: all s_* = bus inputs, SRAM* = b_SRAM*, HREADYOUT = s_HREADYOUT.
REQ-016 init_start in any state other than IDLE SHALL be ignored; in IDLE it sets start_pend.
REQ-017 IDLE->CLEAR SHALL occur when start_pend=1 and the cycle has no accepted address phase (HSEL&HTRANS[1]&HREADY) and no bridge data phase (registered acceptance), so the bridge flushes its write buffer in that gap cycle; start_pend clears on entry.
REQ-018 CLEAR: SRAMCS=1, SRAMWEN=4'hF, SRAMADDR=cnt, SRAMWDATA=INIT_VALUE; b_SRAM* ignored; s_HSEL=0, s_HTRANS=2'b00.
REQ-019 cnt (AW-2 bits) SHALL reset to 0 on CLEAR entry and increment by 1 each CLEAR cycle; clear latency is exactly 2^(AW-2) cycles.
REQ-020 At cnt = all-ones: init_done<=1 and next state = REPLAY if cap_v=1, else IDLE; init_done clears on CLEAR entry.
REQ-021 In CLEAR, an accepted address phase SHALL be captured (HADDR, HTRANS, HWRITE, HSIZE -> cap regs, cap_v<=1), including one in the final CLEAR cycle.
REQ-022 HREADYOUT SHALL be 0 whenever cap_v=1, and 1 in CLEAR with cap_v=0; hence at most one capture per clear.
REQ-023 REPLAY (one cycle): s_HSEL=1, s_* = cap regs, s_HREADY=1, HREADYOUT=0, SRAM* = b_SRAM*; cap_v<=0; next state IDLE.
REQ-024 Cycle after REPLAY: bridge data phase live, HREADYOUT = s_HREADYOUT (1); the master's held HWDATA/read data complete normally.
REQ-025 A read hitting the bridge's forwarding buffer after a software clear returns the forwarded word; this is a documented limitation, not a bug.

Reset
REQ-026 On HRESET: state = CLEAR if AUTO_INIT else IDLE; cnt=0, cap_v=0, start_pend=0, init_done=0.
REQ-027 Reset mid-CLEAR SHALL restart from address 0 and discard any captured transfer; outputs after reset: HREADYOUT=1, init_busy=SRAMCS=AUTO_INIT.

Verification
REQ-028 AW=6, AUTO_INIT=1, reset, no traffic -> 16 cycles SRAMCS=1, WEN=F, ADDR 0..15, WDATA 0; cycle 17 init_busy=0, init_done=1.
REQ-029 Word read to 0x08 accepted in CLEAR cycle 3 -> HREADYOUT=0 until REPLAY ends; REPLAY shows s_HADDR=0x08, s_HTRANS=2'b10, s_HREADY=1; next cycle HREADYOUT=1, HRDATA=INIT_VALUE.
REQ-030 Word write 0x0C data 0xA5A5A5A5 during CLEAR, then read 0x0C -> 0xA5A5A5A5 (not overwritten by clear).
REQ-031 init_start during back-to-back transfers -> CLEAR begins only after the first gap cycle; second init_start during CLEAR -> cnt not restarted.
REQ-032 HRESET at cnt=7 with cap_v=1 -> next cycle cnt=0, cap_v=0, HREADYOUT=1.
REQ-033 AUTO_INIT=0: reset -> IDLE, no SRAM writes; init_start in idle bus -> CLEAR starts 2 cycles later.

Source files
------------

// File: rtl/sram_init_ctrl.sv
// SRAM clear controller between an AHB slave port and its SRAM bridge: fills the macro with INIT_VALUE
// after reset or on request, stalls a bus transfer that arrives mid-clear and replays it to the bridge afterwards.
module sram_init_ctrl #(
  parameter int          AW         = 12,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
  parameter bit          AUTO_INIT  = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESET,

  input  logic          HSEL,
  input  logic [1:0]    HTRANS,
  input  logic [31:0]   HADDR,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  output logic          HREADYOUT,

  output logic          s_HSEL,
  output logic [1:0]    s_HTRANS,
  output logic [31:0]   s_HADDR,
  output logic          s_HWRITE,
  output logic [2:0]    s_HSIZE,
  output logic          s_HREADY,
  input  logic          s_HREADYOUT,

  input  logic          b_SRAMCS,
  input  logic [3:0]    b_SRAMWEN,
  input  logic [AW-3:0] b_SRAMADDR,
  input  logic [31:0]   b_SRAMWDATA,

  output logic          SRAMCS,
  output logic [3:0]    SRAMWEN,
  output logic [AW-3:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,

  input  logic          init_start,
  output logic          init_busy,
  output logic          init_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    REPLAY = 2'd2
  } state_t;

  state_t        state;
  logic [AW-3:0] cnt;
  logic          cap_v;
  logic          start_pend;
  logic          dphase;
  logic          accept;
  logic          cap_now;

  logic [31:0]   cap_haddr;
  logic [1:0]    cap_htrans;
  logic          cap_hwrite;
  logic [2:0]    cap_hsize;

  assign accept  = HSEL & HTRANS[1] & HREADY;
  assign cap_now = (state == CLEAR) & accept & ~cap_v;

  // Control FSM; init_busy is kept as a registered copy of (state != IDLE).
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= AUTO_INIT ? CLEAR : IDLE;
      init_busy  <= AUTO_INIT;
      cnt        <= '0;
      cap_v      <= 1'b0;
      start_pend <= 1'b0;
      init_done  <= 1'b0;
      dphase     <= 1'b0;
    end else begin
      dphase <= s_HSEL & s_HTRANS[1] & s_HREADY;
      case (state)
        IDLE: begin
          // Wait for a cycle with neither an address nor a data phase so the bridge can drain.
          if (start_pend && !accept && !dphase) begin
            state      <= CLEAR;
            init_busy  <= 1'b1;
            start_pend <= 1'b0;
            cnt        <= '0;
            init_done  <= 1'b0;
          end else if (init_start) begin
            start_pend <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cap_now)
            cap_v <= 1'b1;
          if (&cnt) begin
            init_done <= 1'b1;
            if (cap_v || cap_now) begin
              state <= REPLAY;
            end else begin
              state     <= IDLE;
              init_busy <= 1'b0;
            end
          end
        end
        REPLAY: begin
          cap_v     <= 1'b0;
          state     <= IDLE;
          init_busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

  // Captured address phase is plain data; cap_v qualifies it.
  always_ff @(posedge HCLK) begin
    if (cap_now) begin
      cap_haddr  <= HADDR;
      cap_htrans <= HTRANS;
      cap_hwrite <= HWRITE;
      cap_hsize  <= HSIZE;
    end
  end

  always_comb begin
    s_HSEL    = HSEL;
    s_HTRANS  = HTRANS;
    s_HADDR   = HADDR;
    s_HWRITE  = HWRITE;
    s_HSIZE   = HSIZE;
    s_HREADY  = HREADY;
    HREADYOUT = s_HREADYOUT;
    SRAMCS    = b_SRAMCS;
    SRAMWEN   = b_SRAMWEN;
    SRAMADDR  = b_SRAMADDR;
    SRAMWDATA = b_SRAMWDATA;
    case (state)
      CLEAR: begin
        s_HSEL    = 1'b0;
        s_HTRANS  = 2'b00;
        HREADYOUT = ~cap_v;
        SRAMCS    = 1'b1;
        SRAMWEN   = 4'hF;
        SRAMADDR  = cnt;
        SRAMWDATA = INIT_VALUE;
      end
      REPLAY: begin
        s_HSEL    = 1'b1;
        s_HTRANS  = cap_htrans;
        s_HADDR   = cap_haddr;
        s_HWRITE  = cap_hwrite;
        s_HSIZE   = cap_hsize;
        s_HREADY  = 1'b1;
        HREADYOUT = 1'b0;
      end
      default: ;
    endcase
    if (cap_v)
      HREADYOUT = 1'b0;
  end

endmodule

// File: tb/tb_sram_init_ctrl.sv
// Bench for sram_init_ctrl: a simple AHB master, a one-cycle SRAM bridge and an SRAM array around the DUT;
// read data is scored against a reference memory through an expected-value queue.
module tb_sram_init_ctrl;
  localparam int          AW  = 6;
  localparam int          NW  = 16;
  localparam logic [31:0] IV  = 32'h1357_9BDF;
  localparam logic [31:0] IV0 = 32'h5A5A_0F0F;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic          HSEL, HWRITE, HREADY, HREADYOUT;
  logic [1:0]    HTRANS;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [2:0]    HSIZE;
  logic          s_HSEL, s_HWRITE, s_HREADY;
  logic [1:0]    s_HTRANS;
  logic [31:0]   s_HADDR;
  logic [2:0]    s_HSIZE;
  logic          b_SRAMCS;
  logic [3:0]    b_SRAMWEN;
  logic [AW-3:0] b_SRAMADDR;
  logic [31:0]   b_SRAMWDATA;
  logic          SRAMCS;
  logic [3:0]    SRAMWEN;
  logic [AW-3:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic          init_start, init_busy, init_done;

  logic          init_start0, init_busy0, init_done0, HREADYOUT0;
  logic          s_HSEL0, s_HWRITE0, s_HREADY0;
  logic [1:0]    s_HTRANS0;
  logic [31:0]   s_HADDR0;
  logic [2:0]    s_HSIZE0;
  logic          SRAMCS0;
  logic [3:0]    SRAMWEN0;
  logic [AW-3:0] SRAMADDR0;
  logic [31:0]   SRAMWDATA0;

  assign HREADY = HREADYOUT;

  sram_init_ctrl #(.AW(AW), .INIT_VALUE(IV), .AUTO_INIT(1'b1)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT),
    .s_HSEL(s_HSEL), .s_HTRANS(s_HTRANS), .s_HADDR(s_HADDR), .s_HWRITE(s_HWRITE), .s_HSIZE(s_HSIZE),
    .s_HREADY(s_HREADY), .s_HREADYOUT(1'b1),
    .b_SRAMCS(b_SRAMCS), .b_SRAMWEN(b_SRAMWEN), .b_SRAMADDR(b_SRAMADDR), .b_SRAMWDATA(b_SRAMWDATA),
    .SRAMCS(SRAMCS), .SRAMWEN(SRAMWEN), .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done)
  );

  sram_init_ctrl #(.AW(AW), .INIT_VALUE(IV0), .AUTO_INIT(1'b0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL(1'b0), .HTRANS(2'b00), .HADDR(32'h0), .HWRITE(1'b0), .HSIZE(3'b010), .HREADY(1'b1),
    .HREADYOUT(HREADYOUT0),
    .s_HSEL(s_HSEL0), .s_HTRANS(s_HTRANS0), .s_HADDR(s_HADDR0), .s_HWRITE(s_HWRITE0), .s_HSIZE(s_HSIZE0),
    .s_HREADY(s_HREADY0), .s_HREADYOUT(1'b1),
    .b_SRAMCS(1'b0), .b_SRAMWEN(4'h0), .b_SRAMADDR(4'h0), .b_SRAMWDATA(32'h0),
    .SRAMCS(SRAMCS0), .SRAMWEN(SRAMWEN0), .SRAMADDR(SRAMADDR0), .SRAMWDATA(SRAMWDATA0),
    .init_start(init_start0), .init_busy(init_busy0), .init_done(init_done0)
  );

  // Bridge: accepts on s_*, issues the SRAM access in the following (single-cycle) data phase.
  logic        dp_v, dp_write;
  logic [31:0] dp_addr;
  always @(posedge HCLK) begin
    if (HRESET) dp_v <= 1'b0;
    else        dp_v <= s_HSEL & s_HTRANS[1] & s_HREADY;
    if (s_HSEL & s_HTRANS[1] & s_HREADY) begin
      dp_write <= s_HWRITE;
      dp_addr  <= s_HADDR;
    end
  end
  assign b_SRAMCS    = dp_v;
  assign b_SRAMWEN   = (dp_v && dp_write) ? 4'hF : 4'h0;
  assign b_SRAMADDR  = dp_addr[5:2];
  assign b_SRAMWDATA = HWDATA;

  logic [31:0] mem [NW];
  always @(posedge HCLK) begin
    if (SRAMCS)
      for (int b = 0; b < 4; b++)
        if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
  end
  assign HRDATA = mem[dp_addr[5:2]];

  logic [31:0] ref_mem [NW];
  logic [31:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Read-data scoreboard
  logic mon_rd;
  always @(posedge HCLK) begin
    if (HRESET)         mon_rd <= 1'b0;
    else if (HREADYOUT) mon_rd <= HSEL & HTRANS[1] & ~HWRITE;
  end
  always @(negedge HCLK) begin
    if (mon_rd && HREADYOUT) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'(exp_q.size()), 32'd1);
      else                   check("rd_data", HRDATA, exp_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HSIZE = 3'b010;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < NW; i++) ref_mem[i] = IV;
  endtask

  task automatic do_reset();
    HRESET = 1'b1; bus_idle(); init_start = 1'b0; init_start0 = 1'b0;
    cyc();
    @(negedge HCLK);
    check("rst_hready", 32'(HREADYOUT), 32'd1);
    check("rst_busy",   32'(init_busy), 32'd1);
    check("rst_cs",     32'(SRAMCS),    32'd1);
    check("rst_done",   32'(init_done), 32'd0);
    cyc();
    HRESET = 1'b0;
    exp_q.delete();
    ref_clear();
  endtask

  task automatic wait_rdy(output logic ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 64) begin
      @(negedge HCLK);
      ok = HREADYOUT;
      cyc();
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (init_busy && n < 64) begin
      cyc();
      n++;
    end
    check(tag, 32'(init_busy), 32'd0);
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    logic ok;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1; HSIZE = 3'b010;
    wait_rdy(ok);
    ref_mem[a[5:2]] = d;
    bus_idle();
    HWDATA = d;
    wait_rdy(ok);
    check("wr_complete", 32'(ok), 32'd1);
  endtask

  task automatic ahb_read(input logic [31:0] a);
    logic ok;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0; HSIZE = 3'b010;
    wait_rdy(ok);
    exp_q.push_back(ref_mem[a[5:2]]);
    bus_idle();
    wait_rdy(ok);
    check("rd_complete", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HWDATA = 32'h0;
    bus_idle();
    init_start = 1'b0; init_start0 = 1'b0;

    // Power-up clear with no traffic; the AUTO_INIT=0 instance is started by request alongside.
    do_reset();
    for (int i = 0; i < NW; i++) begin
      init_start0 = (i == 2);
      @(negedge HCLK);
      check("clr_cs",    32'(SRAMCS),    32'd1);
      check("clr_wen",   32'(SRAMWEN),   32'hF);
      check("clr_addr",  32'(SRAMADDR),  i);
      check("clr_wdata", SRAMWDATA,      IV);
      check("clr_busy",  32'(init_busy), 32'd1);
      check("clr_done",  32'(init_done), 32'd0);
      check("clr_hrdy",  32'(HREADYOUT), 32'd1);
      if (i == 0) begin
        check("d0_rst_busy", 32'(init_busy0), 32'd0);
        check("d0_rst_cs",   32'(SRAMCS0),    32'd0);
      end
      if (i == 3) check("d0_pend_busy", 32'(init_busy0), 32'd0);
      if (i == 4) begin
        check("d0_clr_busy",  32'(init_busy0), 32'd1);
        check("d0_clr_cs",    32'(SRAMCS0),    32'd1);
        check("d0_clr_addr",  32'(SRAMADDR0),  32'd0);
        check("d0_clr_wdata", SRAMWDATA0,      IV0);
      end
      cyc();
    end
    init_start0 = 1'b0;
    @(negedge HCLK);
    check("end_busy", 32'(init_busy), 32'd0);
    check("end_done", 32'(init_done), 32'd1);
    check("end_cs",   32'(SRAMCS),    32'd0);
    cyc();

    // Read of 0x08 accepted in clear cycle 3, stalled and replayed.
    do_reset();
    repeat (3) cyc();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h08; HWRITE = 1'b0; HSIZE = 3'b010;
    @(negedge HCLK);
    check("cap_hrdy", 32'(HREADYOUT), 32'd1);
    check("cap_addr", 32'(SRAMADDR),  32'd3);
    cyc();
    exp_q.push_back(ref_mem[2]);
    bus_idle();
    for (int c = 4; c <= 16; c++) begin
      @(negedge HCLK);
      check("stall_hrdy", 32'(HREADYOUT), 32'd0);
      if (c == 15) check("last_clr_shsel", 32'(s_HSEL), 32'd0);
      if (c == 16) begin
        check("rep_shsel",   32'(s_HSEL),    32'd1);
        check("rep_shaddr",  s_HADDR,        32'h08);
        check("rep_shtrans", 32'(s_HTRANS),  32'd2);
        check("rep_shwrite", 32'(s_HWRITE),  32'd0);
        check("rep_shsize",  32'(s_HSIZE),   32'd2);
        check("rep_shready", 32'(s_HREADY),  32'd1);
        check("rep_busy",    32'(init_busy), 32'd1);
        check("rep_done",    32'(init_done), 32'd1);
      end
      cyc();
    end
    @(negedge HCLK);
    check("post_rep_hrdy", 32'(HREADYOUT), 32'd1);
    check("post_rep_busy", 32'(init_busy), 32'd0);
    cyc();

    // init_start during back-to-back writes: clear waits for the first gap cycle.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h00; HWRITE = 1'b1; init_start = 1'b1;
    ref_mem[0] = 32'h1111_0000;
    @(negedge HCLK);
    check("pp_shsel", 32'(s_HSEL), 32'd1);
    cyc();
    init_start = 1'b0; HADDR = 32'h04; HWDATA = 32'h1111_0000;
    ref_mem[1] = 32'h2222_0001;
    @(negedge HCLK);
    check("pp_busy1",  32'(init_busy), 32'd0);
    check("pp_shaddr", s_HADDR,        32'h04);
    check("pp_addr1",  32'(SRAMADDR),  32'd0);
    check("pp_wen1",   32'(SRAMWEN),   32'hF);
    check("pp_wdata1", SRAMWDATA,      32'h1111_0000);
    cyc();
    bus_idle(); HWDATA = 32'h2222_0001;
    @(negedge HCLK);
    check("pp_busy2",  32'(init_busy), 32'd0);
    check("pp_addr2",  32'(SRAMADDR),  32'd1);
    check("pp_wdata2", SRAMWDATA,      32'h2222_0001);
    cyc();
    @(negedge HCLK);
    check("gap_busy", 32'(init_busy), 32'd0);
    check("gap_cs",   32'(SRAMCS),    32'd0);
    cyc();
    ref_clear();
    @(negedge HCLK);
    check("sw_clr_busy", 32'(init_busy), 32'd1);
    check("sw_clr_addr", 32'(SRAMADDR),  32'd0);
    check("sw_clr_done", 32'(init_done), 32'd0);
    repeat (3) cyc();
    init_start = 1'b1;
    @(negedge HCLK);
    check("re_start_addr3", 32'(SRAMADDR), 32'd3);
    cyc();
    init_start = 1'b0;
    @(negedge HCLK);
    check("re_start_addr4", 32'(SRAMADDR), 32'd4);
    cyc();
    // Write during clear must survive the clear.
    ahb_write(32'h0C, 32'hA5A5_A5A5);
    repeat (3) cyc();
    check("no_restart", 32'(init_busy), 32'd0);
    ahb_read(32'h0C);
    ahb_read(32'h08);
    ahb_read(32'h00);

    // Reset at cnt=7 with a captured transfer pending.
    do_reset();
    repeat (2) cyc();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h10; HWRITE = 1'b0;
    cyc();
    bus_idle();
    repeat (4) cyc();
    @(negedge HCLK);
    check("pre_rst_addr", 32'(SRAMADDR),  32'd7);
    check("pre_rst_hrdy", 32'(HREADYOUT), 32'd0);
    HRESET = 1'b1;
    cyc();
    HRESET = 1'b0;
    ref_clear();
    @(negedge HCLK);
    check("mid_rst_addr", 32'(SRAMADDR),   32'd0);
    check("mid_rst_hrdy", 32'(HREADYOUT),  32'd1);
    check("mid_rst_busy", 32'(init_busy),  32'd1);
    check("d0_mid_busy",  32'(init_busy0), 32'd0);
    check("d0_mid_cs",    32'(SRAMCS0),    32'd0);
    cyc();
    @(negedge HCLK);
    check("mid_rst_next", 32'(SRAMADDR), 32'd1);
    cyc();
    wait_idle("mid_rst_finish");
    ahb_read(32'h10);
    repeat (2) cyc();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
